// File: rtl/tcp_pkg.sv
// Shared TCP retransmit-timer types and default constants.
// Timer record layout and default timing parameters.
package tcp_pkg;

    localparam int RT_TIMEOUT_CYCLES = 250000000;
    localparam int RT_MAX_BACKOFF    = 6;
    localparam int RT_TS_W           = 64;
    localparam int RT_BO_W           = $clog2(RT_MAX_BACKOFF + 1);

    typedef struct packed {
        logic [RT_TS_W-1:0] deadline;
        logic               armed;
        logic [RT_BO_W-1:0] backoff;
        logic               pend;
    } rt_timer_struct;

endpackage

// File: rtl/tcp_rt_timer_table.sv
// Per-flow retransmit timers with round-robin expiry scanner and
// a single valid/ready expiry event register.
module tcp_rt_timer_table
    import tcp_pkg::*;
#(
    parameter int NUM_FLOWS    = 8,
    parameter int FLOWID_W     = $clog2(NUM_FLOWS),
    parameter int TIMESTAMP_W  = 64,
    parameter int BASE_TIMEOUT = RT_TIMEOUT_CYCLES,
    parameter int MAX_BACKOFF  = RT_MAX_BACKOFF,
    parameter int BACKOFF_W    = $clog2(MAX_BACKOFF + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm_val,
    input  logic [FLOWID_W-1:0]  arm_flowid,
    input  logic                 disarm_val,
    input  logic [FLOWID_W-1:0]  disarm_flowid,
    input  logic                 disarm_clr_backoff,
    output logic                 timeout_val,
    output logic [FLOWID_W-1:0]  timeout_flowid,
    output logic [BACKOFF_W-1:0] timeout_backoff,
    input  logic                 timeout_rdy
);

    // Same field set as rt_timer_struct, sized by this instance's parameters.
    typedef struct packed {
        logic [TIMESTAMP_W-1:0] deadline;
        logic                   armed;
        logic [BACKOFF_W-1:0]   backoff;
        logic                   pend;
    } flow_t;

    localparam logic [TIMESTAMP_W-1:0] BASE_T = TIMESTAMP_W'(BASE_TIMEOUT);
    localparam logic [BACKOFF_W-1:0]   MAX_BO = BACKOFF_W'(MAX_BACKOFF);
    localparam logic [FLOWID_W-1:0]    LAST   = FLOWID_W'(NUM_FLOWS - 1);

    flow_t                  fl_q [NUM_FLOWS];
    flow_t                  fl_d [NUM_FLOWS];
    logic [TIMESTAMP_W-1:0] now_q;
    logic [FLOWID_W-1:0]    scan_q, scan_d;
    logic                   ev_val_q, ev_val_d;
    logic [FLOWID_W-1:0]    ev_fid_q, ev_fid_d;
    logic [BACKOFF_W-1:0]   ev_bo_q, ev_bo_d;

    logic                 hs;
    logic                 can_scan;
    logic                 expire;
    logic                 scan_hit;
    logic                 same_flow;
    logic [BACKOFF_W-1:0] arm_bo;
    logic [BACKOFF_W-1:0] hs_bo;

    assign hs        = ev_val_q & timeout_rdy;
    assign can_scan  = ~ev_val_q | timeout_rdy;
    assign expire    = fl_q[scan_q].armed & ~fl_q[scan_q].pend
                     & (now_q >= fl_q[scan_q].deadline);
    assign scan_hit  = (arm_val & (arm_flowid == scan_q))
                     | (disarm_val & (disarm_flowid == scan_q));
    assign same_flow = disarm_val & (disarm_flowid == arm_flowid);
    assign arm_bo    = (same_flow & disarm_clr_backoff) ? '0
                     : fl_q[arm_flowid].backoff;
    assign hs_bo     = (fl_q[ev_fid_q].backoff == MAX_BO) ? MAX_BO
                     : fl_q[ev_fid_q].backoff + BACKOFF_W'(1);

    always_comb begin
        fl_d     = fl_q;
        scan_d   = scan_q;
        ev_val_d = ev_val_q;
        ev_fid_d = ev_fid_q;
        ev_bo_d  = ev_bo_q;

        if (hs) begin
            ev_val_d = 1'b0;
            if (fl_q[ev_fid_q].pend) begin
                fl_d[ev_fid_q].armed   = 1'b0;
                fl_d[ev_fid_q].pend    = 1'b0;
                fl_d[ev_fid_q].backoff = hs_bo;
            end
        end

        if (can_scan) begin
            scan_d = (scan_q == LAST) ? '0 : scan_q + FLOWID_W'(1);
            if (expire && !scan_hit) begin
                ev_val_d            = 1'b1;
                ev_fid_d            = scan_q;
                ev_bo_d             = fl_q[scan_q].backoff;
                fl_d[scan_q].pend   = 1'b1;
            end
        end

        // Host requests are applied last so they override the handshake update.
        if (disarm_val) begin
            fl_d[disarm_flowid].armed   = 1'b0;
            fl_d[disarm_flowid].pend    = 1'b0;
            fl_d[disarm_flowid].backoff = disarm_clr_backoff ? '0
                                        : fl_q[disarm_flowid].backoff;
        end

        if (arm_val) begin
            fl_d[arm_flowid].armed    = 1'b1;
            fl_d[arm_flowid].pend     = 1'b0;
            fl_d[arm_flowid].backoff  = arm_bo;
            fl_d[arm_flowid].deadline = now_q + (BASE_T << arm_bo);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            now_q    <= '0;
            scan_q   <= '0;
            ev_val_q <= 1'b0;
            ev_fid_q <= '0;
            ev_bo_q  <= '0;
            for (int i = 0; i < NUM_FLOWS; i++) begin
                fl_q[i] <= '0;
            end
        end else begin
            now_q    <= now_q + TIMESTAMP_W'(1);
            scan_q   <= scan_d;
            ev_val_q <= ev_val_d;
            ev_fid_q <= ev_fid_d;
            ev_bo_q  <= ev_bo_d;
            fl_q     <= fl_d;
        end
    end

    assign timeout_val     = ev_val_q;
    assign timeout_flowid  = ev_fid_q;
    assign timeout_backoff = ev_bo_q;

endmodule

// File: doc/tcp_rt_timer_table.md
TCP_RT_TIMER_TABLE -- requirements
Module: tcp_rt_timer_table

Interface
REQ-001 Parameter NUM_FLOWS, default 8, number of independent per-flow retransmit timers.
REQ-002 Parameter FLOWID_W, default $clog2(NUM_FLOWS), flow index width.
REQ-003 Parameter TIMESTAMP_W, default 64, cycle-counter and deadline width.
REQ-004 Parameter BASE_TIMEOUT, default 250000000, first-attempt timeout in cycles (1 s).
REQ-005 Parameter MAX_BACKOFF, default 6, saturation value of the per-flow backoff exponent.
REQ-006 Parameter BACKOFF_W, default $clog2(MAX_BACKOFF+1), backoff field width.
REQ-007 clk  input  1  sole clock.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 arm_val  input  1  request to (re)start the timer of arm_flowid.
REQ-010 arm_flowid  input  FLOWID_W  flow to arm.
REQ-011 disarm_val  input  1  request to stop the timer of disarm_flowid (new ACK received).
REQ-012 disarm_flowid  input  FLOWID_W  flow to disarm.
REQ-013 disarm_clr_backoff  input  1  with disarm_val: reset that flow's backoff to 0.
REQ-014 timeout_val  output  1  expiry event pending.
REQ-015 timeout_flowid  output  FLOWID_W  expired flow.
REQ-016 timeout_backoff  output  BACKOFF_W  backoff exponent in force when the timer expired.
REQ-017 timeout_rdy  input  1  consumer accepts the expiry event.

Function
REQ-018 Internal free-running counter now, TIMESTAMP_W bits, increments every cycle, wraps modulo 2^TIMESTAMP_W.
REQ-019 Per-flow state: armed (1b), deadline (TIMESTAMP_W), backoff (BACKOFF_W), pend (1b).
REQ-020 arm_val: flow armed=1, deadline=now+(BASE_TIMEOUT<<backoff), pend=0; takes effect next cycle; always accepted.
REQ-021 disarm_val: flow armed=0, pend=0; backoff=0 if disarm_clr_backoff, else unchanged; always accepted.
REQ-022 arm and disarm same flow same cycle: disarm (incl. backoff clear) applied first, then arm; flow ends armed, deadline computed with post-clear backoff.
REQ-023 arm/disarm on different flows same cycle: both applied independently.
REQ-024 Deadline arithmetic in TIMESTAMP_W bits; shift saturates at MAX_BACKOFF; overflow wraps and is not detected.
REQ-025 Scanner: scan pointer visits flows round-robin, one per cycle, wrapping NUM_FLOWS-1 -> 0.
REQ-026 Flow expires when armed=1, pend=0, now >= deadline (unsigned compare).
REQ-027 On expiry with no event held: register timeout_val=1, flowid, current backoff; set that flow's pend=1; outputs valid next cycle.
REQ-028 While timeout_val=1 and timeout_rdy=0: scan pointer holds, outputs stable, no new event captured.
REQ-029 Handshake (timeout_val & timeout_rdy): timeout_val drops next cycle unless a new expiry is captured that same cycle (back-to-back allowed).
REQ-030 On handshake, if the flow's pend is still 1: armed=0, pend=0, backoff=min(backoff+1, MAX_BACKOFF); if pend is 0 (arm/disarm occurred since capture): flow state untouched; event still delivered (stale, consumer tolerates).
REQ-031 Arm/disarm for a flow in the same cycle as its handshake: arm/disarm wins; handshake update suppressed.
REQ-032 Detection latency: at most NUM_FLOWS+1 cycles after deadline, excluding backpressure stalls.

Reset
REQ-033 On rst: now=0, all armed=0, pend=0, backoff=0, deadline=0, scan pointer=0, timeout_val=0, timeout_flowid=0, timeout_backoff=0.
REQ-034 Reset mid-event discards any held expiry; arm/disarm presented during rst are ignored.

Structure
REQ-035 Typedef rt_timer_struct {deadline, armed, backoff, pend} and constants BASE_TIMEOUT default (RT_TIMEOUT_CYCLES) and MAX_BACKOFF reside in tcp_pkg.
REQ-036 Flow state kept in a flop array (NUM_FLOWS small); no sub-module required.

Verification (BASE_TIMEOUT=100, NUM_FLOWS=8, MAX_BACKOFF=3)
REQ-037 Arm flow 2 at now=10, rdy=1 -> single timeout_val, flowid=2, backoff=0, asserted between now=110 and 119.
REQ-038 Re-arm flow 2 after each expiry, 5 times -> deadlines +100,+200,+400,+800,+800; reported backoffs 0,1,2,3,3.
REQ-039 Arm flow 5, disarm at now+50 with clr=1 -> no event ever; backoff of flow 5 reads 0 on next arm (expiry at +100).
REQ-040 Arm flows 0,3,7 same deadline, rdy=0 for 40 cycles -> event for flow 0 held stable 40 cycles; then 0,3,7 delivered in scan order, no loss or duplication.
REQ-041 Flow 4 event held, arm flow 4 before handshake -> stale event delivered, flow 4 stays armed with fresh deadline, backoff unchanged.
REQ-042 rst asserted while event held and flows armed -> timeout_val=0 next cycle, no events afterwards until re-armed.
